complex_mac_array: RTL

- Parametrised ROWS x COLS array of pipelined complex fixed-point multiply-accumulate lanes for the FFT-domain convolution datapath.
- Each lane multiplies an image-spectrum bin by a kernel-spectrum bin. It accumulates over a runtime-selected number of input channels and emits one saturated complex result per bin.
- Successor to the fixed 16x16 multiplier array plus separate accumulator array.
- Adds a channel-group counter, valid/ready backpressure and saturation.

---
 rtl/complex_mac_array_if.sv | 32 +++
 rtl/complex_mac_array.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/complex_mac_array_if.sv
// Handshake and data bundle for complex_mac_array.
// Ports: input-beat handshake (in_valid/in_ready), num_ch, packed image/kernel bins,
//        result handshake (out_valid/out_ready), packed out bins, ch_cnt debug count.
interface complex_mac_array_if #(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int DW     = 16,
  parameter int MAX_CH = 64
) ();
  localparam int CW = $clog2(MAX_CH + 1);
  localparam int BW = ROWS * COLS * 2 * DW;

  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] num_ch;
  logic [BW-1:0] image;
  logic [BW-1:0] kernel;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out;
  logic [CW-1:0] ch_cnt;

  modport master (
    output in_valid, num_ch, image, kernel, out_ready,
    input  in_ready, out_valid, out, ch_cnt
  );

  modport slave (
    input  in_valid, num_ch, image, kernel, out_ready,
    output in_ready, out_valid, out, ch_cnt
  );
endinterface

// File: rtl/complex_mac_array.sv
// ROWS x COLS complex fixed-point MAC lanes accumulating over a channel group, saturated per-group result.
// Latency: out_valid rises 3 advancing cycles after the group's last beat is accepted.
// Backpressure: whole pipeline stalls (in_ready=0) while a result is held unconsumed.
// Ports: clk, reset (sync, active-high), bus (complex_mac_array_if.slave).
// Optional macro COMPLEX_MAC_ROUND_EN: round-half-up before the FRAC shift instead of truncation.
module complex_mac_array #(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int DW     = 16,
  parameter int FRAC   = 14,
  parameter int GUARD  = 8,
  parameter int MAX_CH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  complex_mac_array_if.slave   bus
);
  localparam int LANES = ROWS * COLS;
  localparam int ACC_W = DW + GUARD;
  localparam int CW    = $clog2(MAX_CH + 1);
  localparam int PW    = 2 * DW + 1;
  localparam int BW    = LANES * 2 * DW;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

`ifdef COMPLEX_MAC_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(2 ** (FRAC - 1));
`endif

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] n_q, n_d, ch_cnt_q, ch_cnt_d, n_sel;
  logic          s1_vld_q, s1_vld_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic [BW-1:0] s1_img_q, s1_img_d, s1_ker_q, s1_ker_d;
  logic          s2_vld_q, s2_vld_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
  logic signed [ACC_W-1:0] s2_re_q [LANES];
  logic signed [ACC_W-1:0] s2_re_d [LANES];
  logic signed [ACC_W-1:0] s2_im_q [LANES];
  logic signed [ACC_W-1:0] s2_im_d [LANES];
  logic signed [ACC_W-1:0] acc_re_q [LANES];
  logic signed [ACC_W-1:0] acc_re_d [LANES];
  logic signed [ACC_W-1:0] acc_im_q [LANES];
  logic signed [ACC_W-1:0] acc_im_d [LANES];
  logic signed [ACC_W-1:0] acc_re_nx [LANES];
  logic signed [ACC_W-1:0] acc_im_nx [LANES];
  logic [BW-1:0] out_q, out_d;
  logic          out_vld_q, out_vld_d;
  logic          en, accept, tag_first, tag_last, s3_load;

  // Sign-extended component of lane k (im selects the high half of the slot).
  function automatic logic signed [PW-1:0] comp(input logic [BW-1:0] v, input int k, input bit im);
    return PW'($signed(v[2*DW*k + (im ? DW : 0) +: DW]));
  endfunction

  function automatic logic signed [ACC_W-1:0] scale(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = p;
`ifdef COMPLEX_MAC_ROUND_EN
    r = r + RND;
`endif
    return ACC_W'(r >>> FRAC);
  endfunction

  // In range iff every bit above the DW-1 sign bit matches it.
  function automatic logic [DW-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1:DW-1] == {(ACC_W-DW+1){v[ACC_W-1]}}) return v[DW-1:0];
    else if (v[ACC_W-1])                                return {1'b1, {(DW-1){1'b0}}};
    else                                                return {1'b0, {(DW-1){1'b1}}};
  endfunction

  assign en            = !(out_vld_q && !bus.out_ready);
  assign accept        = bus.in_valid && en;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_vld_q;
  assign bus.out       = out_q;
  assign bus.ch_cnt    = ch_cnt_q;

  // Group length clamp: 0 means one channel, above MAX_CH saturates.
  always_comb begin
    n_sel = bus.num_ch;
    if (bus.num_ch == '0)               n_sel = CW'(1);
    else if (bus.num_ch > CW'(MAX_CH))  n_sel = CW'(MAX_CH);
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    ch_cnt_d  = ch_cnt_q;
    tag_first = 1'b0;
    tag_last  = 1'b0;
    if (accept) begin
      if (state_q == ST_IDLE) begin
        n_d       = n_sel;
        tag_first = 1'b1;
        ch_cnt_d  = CW'(1);
        if (n_sel == CW'(1)) tag_last = 1'b1;
        else                 state_d  = ST_ACCUM;
      end else if (ch_cnt_q + CW'(1) == n_q) begin
        tag_last = 1'b1;
        ch_cnt_d = '0;
        state_d  = ST_IDLE;
      end else begin
        ch_cnt_d = ch_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    s1_vld_d = s1_vld_q; s1_first_d = s1_first_q; s1_last_d = s1_last_q;
    s1_img_d = s1_img_q; s1_ker_d   = s1_ker_q;
    s2_vld_d = s2_vld_q; s2_first_d = s2_first_q; s2_last_d = s2_last_q;
    s2_re_d  = s2_re_q;  s2_im_d    = s2_im_q;
    if (en) begin
      s1_vld_d   = accept;
      s1_first_d = tag_first;
      s1_last_d  = tag_last;
      s1_img_d   = bus.image;
      s1_ker_d   = bus.kernel;
      s2_vld_d   = s1_vld_q;
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      for (int k = 0; k < LANES; k++) begin
        s2_re_d[k] = scale(comp(s1_img_q, k, 1'b0) * comp(s1_ker_q, k, 1'b0)
                         - comp(s1_img_q, k, 1'b1) * comp(s1_ker_q, k, 1'b1));
        s2_im_d[k] = scale(comp(s1_img_q, k, 1'b0) * comp(s1_ker_q, k, 1'b1)
                         + comp(s1_img_q, k, 1'b1) * comp(s1_ker_q, k, 1'b0));
      end
    end
  end

  // Accumulator: a first beat restarts the sum; additions wrap at ACC_W.
  always_comb begin
    s3_load   = en && s2_vld_q && s2_last_q;
    acc_re_d  = acc_re_q;
    acc_im_d  = acc_im_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    for (int k = 0; k < LANES; k++) begin
      acc_re_nx[k] = s2_first_q ? s2_re_q[k] : acc_re_q[k] + s2_re_q[k];
      acc_im_nx[k] = s2_first_q ? s2_im_q[k] : acc_im_q[k] + s2_im_q[k];
      if (en && s2_vld_q) begin
        acc_re_d[k] = acc_re_nx[k];
        acc_im_d[k] = acc_im_nx[k];
      end
      if (s3_load) begin
        out_d[2*DW*k +: DW]      = sat(acc_re_nx[k]);
        out_d[2*DW*k + DW +: DW] = sat(acc_im_nx[k]);
      end
    end
    // A new result landing in the handshake cycle keeps valid high.
    if (out_vld_q && bus.out_ready) out_vld_d = 1'b0;
    if (s3_load)                    out_vld_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      ch_cnt_q   <= '0;
      s1_vld_q   <= 1'b0; s1_first_q <= 1'b0; s1_last_q <= 1'b0;
      s2_vld_q   <= 1'b0; s2_first_q <= 1'b0; s2_last_q <= 1'b0;
      acc_re_q   <= '{default: '0};
      acc_im_q   <= '{default: '0};
      out_q      <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      ch_cnt_q   <= ch_cnt_d;
      s1_vld_q   <= s1_vld_d; s1_first_q <= s1_first_d; s1_last_q <= s1_last_d;
      s2_vld_q   <= s2_vld_d; s2_first_q <= s2_first_d; s2_last_q <= s2_last_d;
      acc_re_q   <= acc_re_d;
      acc_im_q   <= acc_im_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
    end
  end

  // Operand and product data travel under their valid tags and need no reset.
  always_ff @(posedge clk) begin
    s1_img_q <= s1_img_d;
    s1_ker_q <= s1_ker_d;
    s2_re_q  <= s2_re_d;
    s2_im_q  <= s2_im_d;
  end
endmodule
